alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//   Parametrised multi-cycle ALU for the CPU execute stage. Adds full N/Z/C/V flags,
//   shifts, iterative unsigned multiply and divide, and valid/ready handshakes on
//   both sides. Single-cycle ops and iterative ops share one registered output port.
// PARAMETERS
//   DATA_W   16   operand/result width; power of two, >= 4
//   CNT_W    $clog2(DATA_W)   derived; shift-amount and iteration-counter width
// PORTS
//   clk         in   1        clock, all logic on rising edge
//   rst_n       in   1        asynchronous reset, active low
//   in_valid    in   1        operation request
//   in_ready    out  1        block can accept a request (state IDLE)
//   op          in   4        operation code (see BEHAVIOUR)
//   a_i         in   DATA_W   first operand
//   b_i         in   DATA_W   second operand / shift amount
//   flags_i     in   4        current PSR flags {N,Z,C,V}; C is used by ADDC/SUBC
//   out_valid   out  1        result valid (state DONE)
//   out_ready   in   1        consumer accepts result
//   result      out  DATA_W   result / product low half / quotient
//   result_hi   out  DATA_W   product high half / remainder; 0 for other ops
//   flags_o     out  4        {N,Z,C,V} of the result
//   div_by_zero out  1        DIVU with b_i == 0
// BEHAVIOUR
//   Ops: 0 ADD, 1 ADDC (a+b+C), 2 SUB, 3 SUBC (a-b-C), 4 NAND, 5 NOR, 6 XOR, 7 XNOR,
//     8 SHL, 9 SHR, 10 SRA, 11 MUL (unsigned), 12 DIVU. Codes 13-15: result=a_i,
//     flags_o=flags_i.
//   FSM: IDLE -> (in_valid & in_ready) -> CALC for MUL/DIVU(b!=0), else DONE.
//     CALC runs exactly DATA_W cycles (counter DATA_W-1 down to 0), then DONE.
//     DONE -> (out_ready) -> IDLE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
//   Latency: accept edge to out_valid = 1 cycle (single-cycle ops and DIVU by 0),
//     DATA_W+1 cycles (MUL, DIVU). Operands and op are latched on accept; inputs
//     are ignored outside IDLE.
//   Outputs are registered and stable while out_valid=1 and out_ready=0.
//   Flags: Z = (result==0), N = result[DATA_W-1] for all ops except codes 13-15.
//     ADD/ADDC: C = carry out, V = signed overflow.
//     SUB/SUBC: C = borrow out (1 when a < b + cin, unsigned), V = signed overflow.
//     Logical ops: C=0, V=0.
//     Shifts: amount = b_i[CNT_W-1:0]; C = last bit shifted out (0 if amount 0); V=0.
//     SRA replicates the sign bit.
//   MUL: shift-add, {result_hi,result} = a*b; C=V=(result_hi!=0).
//   DIVU: restoring, result=a/b, result_hi=a%b; C=V=0.
//     b_i==0: result=all ones, result_hi=a_i, div_by_zero=1, V=1, C=0, Z=0, N=1;
//     no CALC cycles.
//   div_by_zero is 0 for every other op; it is updated only when entering DONE.
//   Reset (any state, incl. mid-CALC): state=IDLE, in_ready=1 after release.
//     out_valid, result, result_hi, flags_o, div_by_zero and counter are all 0.
//     The aborted operation produces no output.
// TESTING (DATA_W=16)
//   ADD 0x7FFF+0x0001 -> result 0x8000, N=1 Z=0 C=0 V=1, out_valid 1 cycle after accept
//   SUBC a=0x0000 b=0x0000 flags_i.C=1 -> result 0xFFFF, C=1 (borrow), N=1, V=0
//   MUL 0x1234*0x0100 -> result 0x3400, result_hi 0x0012, C=V=1; out_valid exactly 17
//     cycles after accept; in_ready=0 throughout
//   DIVU 100/7 -> result 14, result_hi 2; DIVU 5/0 -> result 0xFFFF, result_hi 5,
//     div_by_zero=1, 1-cycle latency
//   Backpressure: out_ready=0 for 5 cycles in DONE -> outputs held constant, in_valid
//     ignored; then out_ready=1 -> IDLE next cycle
//   Assert rst_n mid-MUL (cycle 8) -> outputs 0 immediately; after release, new ADD
//     completes normally
//   SHL 0x8001 by 1 -> result 0x0002, C=1; SRA 0x8000 by 15 -> result 0xFFFF, C=0

Source files
------------

// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
//   Request/response bundle between the execute stage and the multi-cycle ALU.
//   master : issues requests (in_valid/op/operands/flags) and consumes results
//   slave  : the ALU; accepts requests with in_ready, presents results with
//            out_valid until out_ready
// Signals
//   in_valid, in_ready            request handshake
//   op[3:0], a_i, b_i, flags_i    operation, operands, current {N,Z,C,V}
//   out_valid, out_ready          result handshake
//   result, result_hi             low/high result words
//   flags_o[3:0], div_by_zero     result flags {N,Z,C,V}, divide-by-zero
// -----------------------------------------------------------------------------
interface alu_mc_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        op;
   logic [DATA_W-1:0] a_i;
   logic [DATA_W-1:0] b_i;
   logic [3:0]        flags_i;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] result_hi;
   logic [3:0]        flags_o;
   logic              div_by_zero;

   modport master (
      output in_valid, op, a_i, b_i, flags_i, out_ready,
      input  in_ready, out_valid, result, result_hi, flags_o, div_by_zero
   );

   modport slave (
      input  in_valid, op, a_i, b_i, flags_i, out_ready,
      output in_ready, out_valid, result, result_hi, flags_o, div_by_zero
   );
endinterface

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
//   Multi-cycle ALU for the execute stage. Add/sub with carry, logic ops and
//   shifts finish one cycle after accept; unsigned MUL (shift-add) and DIVU
//   (restoring) iterate DATA_W cycles. All results leave through one
//   registered port held until the consumer takes it.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : alu_mc_if.slave (request/response handshakes, operands, results)
// -----------------------------------------------------------------------------
module alu_mc #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = $clog2(DATA_W)
) (
   input  logic    clk,
   input  logic    rst_n,
   alu_mc_if.slave bus
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDC = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SUBC = 4'd3;
   localparam logic [3:0] OP_NAND = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_XNOR = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIVU = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // {N, Z} of a result word
   function automatic logic [1:0] f_nz(input logic [DATA_W-1:0] v);
      return {v[DATA_W-1], (v == {DATA_W{1'b0}})};
   endfunction

   state_t            r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_result_hi;
   logic [3:0]        r_flags;
   logic              r_dbz;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_div;
   // r_opa: multiplicand (MUL) or divisor (DIVU)
   // r_hi : partial product high half (MUL) or partial remainder (DIVU)
   // r_lo : multiplier shifting out (MUL) or dividend -> quotient (DIVU)
   logic [DATA_W-1:0] r_opa;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   logic                w_cin;
   logic [DATA_W:0]     w_add;
   logic [DATA_W:0]     w_sub;
   logic                w_add_v;
   logic                w_sub_v;
   logic [CNT_W-1:0]    w_amt;
   logic [2*DATA_W-1:0] w_shl_full;
   logic [2*DATA_W-1:0] w_shr_full;
   logic [2*DATA_W-1:0] w_sra_full;
   logic                w_start_iter;
   logic [DATA_W-1:0]   w_res;
   logic [DATA_W-1:0]   w_res_hi;
   logic [3:0]          w_flags;
   logic                w_dbz;
   logic [DATA_W:0]     w_mul_sum;
   logic [DATA_W:0]     w_div_shift;
   logic [DATA_W:0]     w_div_diff;
   logic [DATA_W-1:0]   w_nxt_hi;
   logic [DATA_W-1:0]   w_nxt_lo;
   logic                w_hi_nz;
   logic [3:0]          w_it_flags;

   assign w_cin = ((bus.op == OP_ADDC) || (bus.op == OP_SUBC)) ? bus.flags_i[1] : 1'b0;
   assign w_add = {1'b0, bus.a_i} + {1'b0, bus.b_i} + {{DATA_W{1'b0}}, w_cin};
   // bit DATA_W of the difference is the borrow out
   assign w_sub = {1'b0, bus.a_i} - {1'b0, bus.b_i} - {{DATA_W{1'b0}}, w_cin};
   assign w_add_v = (bus.a_i[DATA_W-1] == bus.b_i[DATA_W-1]) &&
                    (w_add[DATA_W-1] != bus.a_i[DATA_W-1]);
   assign w_sub_v = (bus.a_i[DATA_W-1] != bus.b_i[DATA_W-1]) &&
                    (w_sub[DATA_W-1] != bus.a_i[DATA_W-1]);

   // Shifting through a double-width word leaves the last bit shifted out at a
   // fixed position (bit DATA_W for SHL, bit DATA_W-1 for right shifts); with
   // amount 0 that position holds zero, so C needs no special case.
   assign w_amt      = bus.b_i[CNT_W-1:0];
   assign w_shl_full = {{DATA_W{1'b0}}, bus.a_i} << w_amt;
   assign w_shr_full = {bus.a_i, {DATA_W{1'b0}}} >> w_amt;
   assign w_sra_full = $signed({bus.a_i, {DATA_W{1'b0}}}) >>> w_amt;

   assign w_start_iter = (bus.op == OP_MUL) ||
                         ((bus.op == OP_DIVU) && (bus.b_i != {DATA_W{1'b0}}));

   // Single-cycle result and flags for the op presented at the input
   always_comb begin
      w_res    = bus.a_i;
      w_res_hi = {DATA_W{1'b0}};
      w_flags  = bus.flags_i;
      w_dbz    = 1'b0;
      case (bus.op)
         OP_ADD, OP_ADDC: begin
            w_res   = w_add[DATA_W-1:0];
            w_flags = {f_nz(w_add[DATA_W-1:0]), w_add[DATA_W], w_add_v};
         end
         OP_SUB, OP_SUBC: begin
            w_res   = w_sub[DATA_W-1:0];
            w_flags = {f_nz(w_sub[DATA_W-1:0]), w_sub[DATA_W], w_sub_v};
         end
         OP_NAND: begin
            w_res   = ~(bus.a_i & bus.b_i);
            w_flags = {f_nz(~(bus.a_i & bus.b_i)), 2'b00};
         end
         OP_NOR: begin
            w_res   = ~(bus.a_i | bus.b_i);
            w_flags = {f_nz(~(bus.a_i | bus.b_i)), 2'b00};
         end
         OP_XOR: begin
            w_res   = bus.a_i ^ bus.b_i;
            w_flags = {f_nz(bus.a_i ^ bus.b_i), 2'b00};
         end
         OP_XNOR: begin
            w_res   = ~(bus.a_i ^ bus.b_i);
            w_flags = {f_nz(~(bus.a_i ^ bus.b_i)), 2'b00};
         end
         OP_SHL: begin
            w_res   = w_shl_full[DATA_W-1:0];
            w_flags = {f_nz(w_shl_full[DATA_W-1:0]), w_shl_full[DATA_W], 1'b0};
         end
         OP_SHR: begin
            w_res   = w_shr_full[2*DATA_W-1:DATA_W];
            w_flags = {f_nz(w_shr_full[2*DATA_W-1:DATA_W]), w_shr_full[DATA_W-1], 1'b0};
         end
         OP_SRA: begin
            w_res   = w_sra_full[2*DATA_W-1:DATA_W];
            w_flags = {f_nz(w_sra_full[2*DATA_W-1:DATA_W]), w_sra_full[DATA_W-1], 1'b0};
         end
         OP_DIVU: begin
            // only reaches the output when b_i == 0 (otherwise iterates)
            w_res    = {DATA_W{1'b1}};
            w_res_hi = bus.a_i;
            w_dbz    = 1'b1;
            w_flags  = 4'b1001;
         end
         default: begin
            w_res    = bus.a_i;
            w_res_hi = {DATA_W{1'b0}};
            w_flags  = bus.flags_i;
            w_dbz    = 1'b0;
         end
      endcase
   end

   assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : {(DATA_W+1){1'b0}});
   assign w_div_shift = {r_hi, r_lo[DATA_W-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_opa};

   // One shift-add or restoring-divide step
   always_comb begin
      if (r_is_div) begin
         if (w_div_diff[DATA_W]) begin
            // trial subtraction went negative: keep the shifted remainder
            w_nxt_hi = w_div_shift[DATA_W-1:0];
            w_nxt_lo = {r_lo[DATA_W-2:0], 1'b0};
         end else begin
            w_nxt_hi = w_div_diff[DATA_W-1:0];
            w_nxt_lo = {r_lo[DATA_W-2:0], 1'b1};
         end
      end else begin
         w_nxt_hi = w_mul_sum[DATA_W:1];
         w_nxt_lo = {w_mul_sum[0], r_lo[DATA_W-1:1]};
      end
   end

   assign w_hi_nz    = (w_nxt_hi != {DATA_W{1'b0}});
   assign w_it_flags = r_is_div ? {f_nz(w_nxt_lo), 2'b00}
                                : {f_nz(w_nxt_lo), w_hi_nz, w_hi_nz};

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= {DATA_W{1'b0}};
         r_result_hi <= {DATA_W{1'b0}};
         r_flags     <= 4'b0000;
         r_dbz       <= 1'b0;
         r_cnt       <= {CNT_W{1'b0}};
         r_is_div    <= 1'b0;
         r_opa       <= {DATA_W{1'b0}};
         r_hi        <= {DATA_W{1'b0}};
         r_lo        <= {DATA_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_in_ready <= 1'b0;
                  if (w_start_iter) begin
                     r_state  <= ST_CALC;
                     r_cnt    <= CNT_W'(DATA_W - 1);
                     r_is_div <= (bus.op == OP_DIVU);
                     r_opa    <= (bus.op == OP_DIVU) ? bus.b_i : bus.a_i;
                     r_lo     <= (bus.op == OP_DIVU) ? bus.a_i : bus.b_i;
                     r_hi     <= {DATA_W{1'b0}};
                  end else begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                     r_result    <= w_res;
                     r_result_hi <= w_res_hi;
                     r_flags     <= w_flags;
                     r_dbz       <= w_dbz;
                  end
               end
            end
            ST_CALC: begin
               r_hi <= w_nxt_hi;
               r_lo <= w_nxt_lo;
               if (r_cnt == {CNT_W{1'b0}}) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_nxt_lo;
                  r_result_hi <= w_nxt_hi;
                  r_flags     <= w_it_flags;
                  r_dbz       <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.result      = r_result;
   assign bus.result_hi   = r_result_hi;
   assign bus.flags_o     = r_flags;
   assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

   typedef struct {
      logic [15:0] res;
      logic [15:0] hi;
      logic [3:0]  fl;
      logic        dbz;
      int          lat;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   in_rst = 1'b1;
   bit   hold_ready = 1'b0;
   bit   rnd_bp = 1'b0;
   bit   seen_valid = 1'b0;
   bit   late_rep = 1'b0;
   exp_t sb[$];

   alu_mc_if #(.DATA_W(16)) bus ();

   alu_mc #(.DATA_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic bit ovf(input int s);
      return (s > 32767) || (s < -32768);
   endfunction

   // Reference model straight from the operation definitions
   function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input logic [3:0] f);
      exp_t e;
      int ua, ub, sa, sbv, c, r, s, amt;
      longint p;
      bit cf, vf, fixed;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sbv = int'($signed(b));
      amt = int'(b[3:0]);
      c = 0; cf = 1'b0; vf = 1'b0; fixed = 1'b0;
      e.hi = 16'h0000; e.dbz = 1'b0; e.lat = 1; e.acc = 0; e.fl = 4'h0;
      case (op)
         4'd0, 4'd1: begin
            if (op == 4'd1) c = int'(f[1]);
            r = ua + ub + c; e.res = 16'(r); cf = (r > 65535);
            s = sa + sbv + c; vf = ovf(s);
         end
         4'd2, 4'd3: begin
            if (op == 4'd3) c = int'(f[1]);
            r = ua - ub - c; e.res = 16'(r); cf = (ua < ub + c);
            s = sa - sbv - c; vf = ovf(s);
         end
         4'd4: e.res = ~(a & b);
         4'd5: e.res = ~(a | b);
         4'd6: e.res = a ^ b;
         4'd7: e.res = ~(a ^ b);
         4'd8: begin
            e.res = 16'(ua << amt);
            cf = (amt != 0) && (((ua >> (16 - amt)) & 1) == 1);
         end
         4'd9: begin
            e.res = 16'(ua >> amt);
            cf = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1);
         end
         4'd10: begin
            e.res = 16'(sa >>> amt);
            cf = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1);
         end
         4'd11: begin
            p = longint'(ua) * longint'(ub);
            e.res = p[15:0]; e.hi = p[31:16];
            cf = (e.hi != 16'h0000); vf = cf; e.lat = 17;
         end
         4'd12: begin
            if (ub == 0) begin
               e.res = 16'hFFFF; e.hi = a; e.dbz = 1'b1;
               e.fl = 4'b1001; fixed = 1'b1;
            end else begin
               e.res = 16'(ua / ub); e.hi = 16'(ua % ub); e.lat = 17;
            end
         end
         default: begin
            e.res = a; e.fl = f; fixed = 1'b1;
         end
      endcase
      if (!fixed) e.fl = {e.res[15], (e.res == 16'h0000), cf, vf};
      return e;
   endfunction

   // Scoreboard monitor: sampled on the falling edge, away from DUT updates
   always @(negedge clk) begin
      if (rst_n && !in_rst) begin
         if (sb.size() == 0) begin
            chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
            chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
         end else begin
            chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid) begin
               if (!seen_valid) begin
                  seen_valid = 1'b1;
                  chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
               end
               chk("result", 32'(bus.result), 32'(sb[0].res));
               chk("result_hi", 32'(bus.result_hi), 32'(sb[0].hi));
               chk("flags_o", 32'(bus.flags_o), 32'(sb[0].fl));
               chk("div_by_zero", 32'(bus.div_by_zero), 32'(sb[0].dbz));
               if (bus.out_ready) begin
                  void'(sb.pop_front());
                  seen_valid = 1'b0;
                  late_rep = 1'b0;
               end
            end else if (!seen_valid && !late_rep && (cyc - sb[0].acc) > sb[0].lat) begin
               late_rep = 1'b1;
               n_checks++;
               n_errors++;
               $display("FAIL latency_late: no out_valid after %0d cycles, expected %0d",
                        cyc - sb[0].acc, sb[0].lat);
            end
         end
      end
   end

   // Consumer backpressure
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (hold_ready) bus.out_ready = 1'b0;
         else if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
         else bus.out_ready = 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic garbage();
      bus.in_valid = 1'b1;
      bus.op       = 4'($urandom);
      bus.a_i      = 16'($urandom);
      bus.b_i      = 16'($urandom);
      bus.flags_i  = 4'($urandom);
   endtask

   // Issue one request; drives junk with in_valid high while the DUT is busy
   task automatic issue(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] f);
      exp_t e;
      int g;
      g = 0;
      while (sb.size() != 0 && g < 300) begin
         garbage();
         @(posedge clk); #1;
         g++;
      end
      if (sb.size() != 0) begin
         n_checks++; n_errors++;
         $display("FAIL issue_wait: DUT busy for %0d cycles", g);
      end
      bus.in_valid = 1'b1; bus.op = op; bus.a_i = a; bus.b_i = b; bus.flags_i = f;
      @(negedge clk);
      chk("accept_ready", 32'(bus.in_ready), 32'd1);
      e = model(op, a, b, f);
      e.acc = cyc;
      @(posedge clk);
      sb.push_back(e);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 400) begin
         @(posedge clk); #1;
         g++;
      end
      if (sb.size() != 0) begin
         n_checks++; n_errors++;
         $display("FAIL drain: %0d results outstanding", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      logic [3:0]  op;
      logic [15:0] a, b;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.op = 4'h0; bus.a_i = 16'h0; bus.b_i = 16'h0; bus.flags_i = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_result_hi", 32'(bus.result_hi), 32'd0);
      chk("rst_flags", 32'(bus.flags_o), 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      in_rst = 1'b0;

      // Directed corner cases
      issue(4'd0,  16'h7FFF, 16'h0001, 4'b0000);
      issue(4'd3,  16'h0000, 16'h0000, 4'b0010);
      issue(4'd11, 16'h1234, 16'h0100, 4'b0000);
      issue(4'd12, 16'd100,  16'd7,    4'b0000);
      issue(4'd12, 16'd5,    16'd0,    4'b0000);
      issue(4'd8,  16'h8001, 16'd1,    4'b0000);
      issue(4'd10, 16'h8000, 16'd15,   4'b0000);
      issue(4'd14, 16'hBEEF, 16'h0001, 4'b1010);
      issue(4'd1,  16'hFFFF, 16'h0000, 4'b0010);
      issue(4'd9,  16'h0003, 16'd0,    4'b0000);

      // Backpressure: result held 5 cycles while junk requests are offered
      drain();
      hold_ready = 1'b1;
      issue(4'd6, 16'hA5A5, 16'h0FF0, 4'b0000);
      repeat (5) begin
         garbage();
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      hold_ready = 1'b0;
      drain();

      // Randomized traffic with random consumer stalls
      rnd_bp = 1'b1;
      for (int i = 0; i < 250; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = 16'($urandom);
         b  = 16'($urandom);
         if (op == 4'd12 && $urandom_range(0, 3) == 0) b = 16'h0000;
         issue(op, a, b, 4'($urandom));
      end
      drain();
      rnd_bp = 1'b0;

      // Reset in the middle of a multiply
      issue(4'd0, 16'h1234, 16'h0001, 4'b0000);
      drain();
      issue(4'd11, 16'hFFFF, 16'hFFFF, 4'b0000);
      repeat (7) @(posedge clk);
      #2;
      in_rst = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_result", 32'(bus.result), 32'd0);
      chk("midrst_result_hi", 32'(bus.result_hi), 32'd0);
      chk("midrst_flags", 32'(bus.flags_o), 32'd0);
      chk("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
      sb.delete();
      seen_valid = 1'b0;
      late_rep = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      in_rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      issue(4'd0, 16'h0101, 16'h0202, 4'b0000);
      drain();
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
